// File: rtl/image_rom_arbiter.sv
// Shares one 1-cycle-latency image ROM between NUM_REQ requesters; 3-stage pipeline, one-hot ack.
// Optional macro ROM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module image_rom_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  input  logic [DATA_WIDTH-1:0]         rom_rgb
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    r_inflight;
  logic [NUM_REQ-1:0]    w_elig, w_set, w_clr;
  logic [1:0]            r_vld_pipe;
  logic [IW-1:0]         r_tag1, r_tag2;
  logic [IW-1:0]         w_start, w_win, w_idx;
  logic                  w_gnt;
  logic [ADDR_WIDTH-1:0] w_addr;

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign w_start = '0;
`else
  logic [IW-1:0] r_ptr;
  assign w_start = r_ptr;
`endif

  assign w_elig = req & ~r_inflight;

  // Walk from the highest search offset down so the first eligible one after w_start wins.
  always_comb begin
    w_gnt = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = IW'((int'(w_start) + k) % NUM_REQ);
      if (w_elig[w_idx]) begin
        w_gnt = 1'b1;
        w_win = w_idx;
      end
    end
  end

  always_comb begin
    w_addr = '0;
    w_set  = '0;
    w_clr  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) w_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      w_set[i] = w_gnt && (w_win == IW'(i));
      w_clr[i] = r_vld_pipe[1] && (r_tag2 == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_inflight <= '0;
      rom_addr   <= '0;
      ack        <= '0;
      rdata      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_gnt};
      r_tag2     <= r_tag1;
      if (w_gnt) begin
        r_tag1   <= w_win;
        rom_addr <= w_addr;
      end
      ack <= w_clr;
      if (r_vld_pipe[1]) rdata <= rom_rgb;
      // Clearing with the ack makes the requester eligible again the following cycle.
      r_inflight <= (r_inflight & ~w_clr) | w_set;
    end
  end

`ifndef ROM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= '0;
    else if (w_gnt) r_ptr <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
  end
`endif

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter: 2- and 4-requester instances, transaction-level model plus literal checks.
module tb_image_rom_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req2, ack2;
  logic [19:0] addr2;
  logic [11:0] rdata2, rgb2;
  logic [9:0]  radr2;
  logic [3:0]  req4, ack4;
  logic [39:0] addr4;
  logic [11:0] rdata4, rgb4;
  logic [9:0]  radr4;

  image_rom_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(10), .DATA_WIDTH(12)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_addr(addr2), .ack(ack2),
    .rdata(rdata2), .rom_addr(radr2), .rom_rgb(rgb2));
  image_rom_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(10), .DATA_WIDTH(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .req_addr(addr4), .ack(ack4),
    .rdata(rdata4), .rom_addr(radr4), .rom_rgb(rgb4));

  function automatic logic [11:0] rom_fn(input int a);
    if (a == 'h021) return 12'hF80;
    return 12'(((a * 37) + 11) ^ (a >> 3));
  endfunction

  // Registered-output ROMs
  always @(posedge clk) begin
    rgb2 <= rom_fn(int'(radr2));
    rgb4 <= rom_fn(int'(radr4));
  end

  int n_cmp, n_bad;
  logic chk_en;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each read is a transaction issued on a clock and answered two clocks later.
  int          iss[2][8];
  logic [9:0]  iad[2][8];
  int          ptr_m[2];
  int          cyc;
  logic [7:0]  e_ack[2];
  logic [11:0] e_rd[2];
  logic [9:0]  e_ra[2];

  task automatic m_clear();
    for (int u = 0; u < 2; u++) begin
      e_ack[u] = '0; e_rd[u] = '0; e_ra[u] = '0; ptr_m[u] = 0;
      for (int i = 0; i < 8; i++) begin iss[u][i] = -1; iad[u][i] = '0; end
    end
  endtask

  task automatic m_step(input int u, input int n, input logic [7:0] rq, input logic [79:0] ad);
    int win, idx;
    logic [7:0] done;
    done = '0;
    win  = -1;
    for (int i = 0; i < n; i++)
      if (iss[u][i] >= 0 && cyc - iss[u][i] == 2) begin
        done[i] = 1'b1;
        e_rd[u] = rom_fn(int'(iad[u][i]));
      end
    for (int k = 0; k < n; k++) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (ptr_m[u] + k) % n;
`endif
      if (win < 0 && rq[idx] && iss[u][idx] < 0) win = idx;
    end
    e_ack[u] = done;
    for (int i = 0; i < n; i++) if (done[i]) iss[u][i] = -1;
    if (win >= 0) begin
      iss[u][win] = cyc;
      iad[u][win] = ad[win*10 +: 10];
      e_ra[u]     = iad[u][win];
      ptr_m[u]    = (win + 1) % n;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_clear();
    else begin
      m_step(0, 2, {6'b0, req2}, {60'b0, addr2});
      m_step(1, 4, {4'b0, req4}, {40'b0, addr4});
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ack2",   32'(ack2),   32'(e_ack[0][1:0]));
      chk("model_rdata2", 32'(rdata2), 32'(e_rd[0]));
      chk("model_radr2",  32'(radr2),  32'(e_ra[0]));
      chk("model_ack4",   32'(ack4),   32'(e_ack[1][3:0]));
      chk("model_rdata4", 32'(rdata4), 32'(e_rd[1]));
      chk("model_radr4",  32'(radr4),  32'(e_ra[1]));
    end
  end

  logic [1:0] p3[8];
  logic [3:0] p5[8];
  int seen;

  initial begin
    rst_n = 1'b0; req2 = '0; req4 = '0; addr2 = '0; addr4 = '0;
    chk_en = 1'b0; n_cmp = 0; n_bad = 0; cyc = 0; seen = 0;
    m_clear();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_ack2", 32'(ack2), 32'h0);
    chk("rst_rdata4", 32'(rdata4), 32'h0);
    chk("rst_radr4", 32'(radr4), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read
    addr2 = {10'h000, 10'h021}; req2 = 2'b01;
    @(negedge clk); chk("t2_romaddr", 32'(radr2), 32'h021);
    @(negedge clk); chk("t2_ack_early", 32'(ack2), 32'h0);
    @(negedge clk); chk("t2_ack", 32'(ack2), 32'h1); chk("t2_rdata", 32'(rdata2), 32'hF80);
    req2 = 2'b00;
    @(negedge clk); chk("t2_ack_pulse", 32'(ack2), 32'h0);
    repeat (2) @(negedge clk);

    // Reset mid-read
    addr2[9:0] = 10'h155; req2 = 2'b01;
    @(negedge clk); chk("t1_romaddr", 32'(radr2), 32'h155);
    #2 rst_n = 1'b0; req2 = 2'b00;
    #1;
    chk("t1_ack", 32'(ack2), 32'h0);
    chk("t1_rdata", 32'(rdata2), 32'h0);
    chk("t1_romaddr0", 32'(radr2), 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (ack2 != 2'b00) seen++;
    end
    chk("t1_no_ack_after_reset", 32'(seen), 32'h0);

    // Two-way contention (same pattern for both policies with two requesters)
    p3 = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00};
    addr2 = {10'h2A5, 10'h3FF}; req2 = 2'b11;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); chk("t3_ack_seq", 32'(ack2), 32'(p3[j]));
    end
    req2 = 2'b00;  // dropped with reads in flight: they still complete

    // Idle hold
    repeat (3) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t6_ack", 32'(ack2), 32'h0);
      chk("t6_romaddr_hold", 32'(radr2), 32'h2A5);
      chk("t6_rdata_hold", 32'(rdata2), 32'(rom_fn('h2A5)));
    end

    // Four requesters all held
`ifdef ROM_ARB_FIXED_PRIO_EN
    p5 = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h1, 4'h2, 4'h4};
`else
    p5 = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
`endif
    addr4 = {10'h0C3, 10'h082, 10'h041, 10'h3FF}; req4 = 4'hF;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk); chk("t5_ack_seq", 32'(ack4), 32'(p5[j]));
    end
    req4 = 4'h0;
    repeat (4) @(negedge clk);

    // Mixed directed traffic, checked by the model
    addr2 = {10'h1E0, 10'h01F}; req2 = 2'b10;
    addr4 = {10'h300, 10'h0FF, 10'h200, 10'h021}; req4 = 4'b0101;
    repeat (5) @(negedge clk);
    req4 = 4'b1110; req2 = 2'b11;
    repeat (6) @(negedge clk);
    req4 = 4'b0000; req2 = 2'b00;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
